div_radix2: RTL and testbench
=============================

DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 The module SHALL expose `clk  input  1`, the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL expose `rst  input  1`, an asynchronous active-low reset; rst=0 resets immediately, independent of clk.
REQ-003 The module SHALL expose `signed_div_i  input  1`, where 1 selects two's-complement division and 0 selects unsigned division.
REQ-004 The module SHALL expose `opdata1_i  input  32`, the dividend.
REQ-005 The module SHALL expose `opdata2_i  input  32`, the divisor.
REQ-006 The module SHALL expose `start_i  input  1`, the request from the EX stage, held high until ready_o is seen.
REQ-007 The module SHALL expose `annul_i  input  1`, which cancels the operation in flight (driven by the EX flush).
REQ-008 The module SHALL expose `result_o  output  64`, formatted as {remainder[31:0] for HI, quotient[31:0] for LO}.
REQ-009 The module SHALL expose `ready_o  output  1`, which is high while result_o is valid.

Function
REQ-010 The block SHALL be a responder FSM with states IDLE, DIVZERO, ON and END.
REQ-011 In IDLE, with start_i=1 and annul_i=0, the block SHALL at the next edge:
- latch signed_div_i, opdata1_i and opdata2_i;
- go to DIVZERO if opdata2_i==0, otherwise to ON.
REQ-012 In IDLE, start_i=1 together with annul_i=1 SHALL leave the state at IDLE.
REQ-013 Operands SHALL be sampled only on the IDLE exit edge; later input changes SHALL be ignored.
REQ-014 In signed mode, latched operands with bit31=1 SHALL be replaced by their two's-complement magnitude before iteration; unsigned mode SHALL use them unchanged.
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle using a 65-bit working register and a 6-bit counter starting at 0, for exactly 32 steps.
REQ-016 When the counter reaches 32, the block SHALL go to END at the next edge.
REQ-017 On that END entry, result_o SHALL be loaded with the sign-corrected result:
- quotient negated when the operand signs differ (signed mode only);
- remainder negated when the dividend is negative (signed mode only).
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, wrapping with no exception.
REQ-019 DIVZERO SHALL go to END at the next edge with result_o = 64'h0.
REQ-020 In END, ready_o SHALL be 1 and result_o SHALL be held stable.
REQ-021 END SHALL go to IDLE at the first edge where start_i=0; ready_o and result_o SHALL read 0 from that edge onward.
REQ-022 In ON or DIVZERO, annul_i=1 or start_i=0 SHALL abort to IDLE at the next edge, with ready_o never asserted for that operation.
REQ-023 In END, annul_i SHALL have no effect other than through start_i.
REQ-024 ready_o SHALL be a registered output, high only in END.
REQ-025 Latency SHALL be:
- nonzero divisor: ready_o rises 34 edges after the edge that samples start_i (1 load edge + 32 steps + 1 END edge);
- zero divisor: ready_o rises 2 edges after that edge.
REQ-026 A new start_i SHALL be accepted no earlier than one cycle after END is left.

Reset
REQ-027 While rst=0, the block SHALL be in state IDLE with:
- counter = 0 and working register = 0;
- result_o = 64'h0 and ready_o = 0.
REQ-028 Reset asserted in any state, including mid-ON, SHALL abort the operation immediately.
REQ-029 After reset release, the first start_i edge SHALL behave per REQ-011.

Verification
REQ-030 Unsigned 100/7, start held: ready_o rises at edge 34 with result_o = {32'd2, 32'd14}; after start_i drops, ready_o=0 at the next edge.
REQ-031 Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-032 Signed and unsigned boundaries:
- signed 0x80000000 / 0xFFFFFFFF gives {32'h0, 32'h80000000};
- unsigned 0xFFFFFFFF / 1 gives {32'h0, 32'hFFFFFFFF};
- unsigned 0xFFFFFFFF / 0xFFFFFFFF gives {32'h0, 32'h1}.
REQ-033 Divisor 0: ready_o rises 2 edges after start with result_o = 64'h0.
REQ-034 annul_i pulsed 10 cycles into ON: state returns to IDLE and ready_o never asserts; a following start (100/7) completes per REQ-030.
REQ-035 rst=0 asserted mid-ON and between clock edges: outputs read 0 immediately; after release, a new 100/7 completes per REQ-030.

Source files
------------

// File: rtl/div_radix2_if.sv
// Request/response bundle between the EX stage and the radix-2 divider.
// The master drives operands and the start/annul handshake; the divider answers with result/ready.
interface div_radix2_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );
endinterface

// File: rtl/div_radix2.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle.
// Result is {remainder, quotient}, held with ready_o until the requester drops start_i.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  div_radix2_if.slave div_if
);

  typedef enum logic [1:0] {
    StIdle,
    StDivZero,
    StOn,
    StEnd
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] diff;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        abort;

  // Operand magnitudes are taken straight from the request so the working
  // register is ready to iterate on the cycle after acceptance.
  always_comb begin
    mag_a = (div_if.signed_div_i && div_if.opdata1_i[31]) ? (~div_if.opdata1_i + 32'd1)
                                                          : div_if.opdata1_i;
    mag_b = (div_if.signed_div_i && div_if.opdata2_i[31]) ? (~div_if.opdata2_i + 32'd1)
                                                          : div_if.opdata2_i;
  end

  // work_q[64:32] holds the partial remainder already shifted by one with the
  // next dividend bit appended; the low bits collect quotient bits.
  always_comb begin
    diff     = work_q[64:32] - {1'b0, divisor_q};
    quot_raw = work_q[31:0];
    rem_raw  = work_q[64:33];
    quot_fix = neg_quot_q ? (~quot_raw + 32'd1) : quot_raw;
    rem_fix  = neg_rem_q ? (~rem_raw + 32'd1) : rem_raw;
    abort    = div_if.annul_i || !div_if.start_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    unique case (state_q)
      StIdle: begin
        if (div_if.start_i && !div_if.annul_i) begin
          divisor_d  = mag_b;
          neg_quot_d = div_if.signed_div_i && (div_if.opdata1_i[31] ^ div_if.opdata2_i[31]);
          neg_rem_d  = div_if.signed_div_i && div_if.opdata1_i[31];
          work_d     = {32'd0, mag_a, 1'b0};
          cnt_d      = 6'd0;
          state_d    = (div_if.opdata2_i == 32'd0) ? StDivZero : StOn;
        end
      end
      StDivZero: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          result_d = 64'd0;
          state_d  = StEnd;
        end
      end
      StOn: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == 6'd32) begin
          result_d = {rem_fix, quot_fix};
          state_d  = StEnd;
        end else begin
          if (diff[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {diff[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      StEnd: begin
        if (!div_if.start_i) begin
          result_d = 64'd0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StEnd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      work_q     <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: vector table for results and latency, plus
// hand-written annul and asynchronous-reset sequences.
module tb_div_radix2;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[11];

  div_radix2_if dif ();

  div_radix2 u_dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after the sample edge; returns how many edges (sample edge = 1)
  // it took until ready_o was seen high, capped at 40.
  task automatic wait_ready(output int lat);
    lat = 1;
    #1;
    while (!dif.ready_o && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    dif.annul_i      = 1'b0;
    @(posedge clk);
    #1;
    // Operands after the sample edge must be ignored.
    dif.signed_div_i = ~sgn;
    dif.opdata1_i    = ~a;
    dif.opdata2_i    = b ^ 32'h0000_5A5A;
    wait_ready(lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, dif.result_o, exp);
    // annul in END must not disturb the held result.
    @(negedge clk);
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    check({name, " hold ready"}, 64'(dif.ready_o), 64'd1);
    check({name, " hold result"}, dif.result_o, exp);
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " drop ready"}, 64'(dif.ready_o), 64'd0);
    check({name, " drop result"}, dif.result_o, 64'd0);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 34};
    vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 34};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF,  32'h00000001,  64'h00000000_FFFFFFFF, 34};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001, 34};
    vecs[5]  = '{1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 34};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  64'hFFFFFFFF_00000003, 34};
    vecs[7]  = '{1'b0, 32'hFFFFFFF9,  32'h00000002,  64'h00000001_7FFFFFFC, 34};
    vecs[8]  = '{1'b0, 32'h00000007,  32'h00000009,  64'h00000007_00000000, 34};
    vecs[9]  = '{1'b0, 32'h12345678,  32'h00000000,  64'h0, 2};
    vecs[10] = '{1'b1, 32'h80000000,  32'h00000000,  64'h0, 2};

    rst              = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    #3;
    check("reset ready", 64'(dif.ready_o), 64'd0);
    check("reset result", dif.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat);
    end

    // Annul 10 cycles into ON, then hold start+annul in IDLE, then restart 100/7.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("annul ready low", 64'(dif.ready_o), 64'd0);
    @(negedge clk);
    dif.annul_i   = 1'b0;
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    @(posedge clk);
    wait_ready(lat);
    check("after annul latency", 64'(lat), 64'd34);
    check("after annul result", dif.result_o, 64'h00000002_0000000E);
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("after annul drop", 64'(dif.ready_o), 64'd0);

    // Asynchronous reset while END holds a result: outputs clear between edges.
    @(negedge clk);
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    @(posedge clk);
    wait_ready(lat);
    check("pre-reset result", dif.result_o, 64'h00000001_0000014D);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async rst ready", 64'(dif.ready_o), 64'd0);
    check("async rst result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-ON with start held; first edge after release starts 100/7.
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid-ON rst ready", 64'(dif.ready_o), 64'd0);
    dif.opdata1_i = 32'd100;
    dif.opdata2_i = 32'd7;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    wait_ready(lat);
    check("post-reset latency", 64'(lat), 64'd34);
    check("post-reset result", dif.result_o, 64'h00000002_0000000E);
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset drop", 64'(dif.ready_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
